l3_port_arbiter: RTL and testbench

- Shares the single L3 data cache access port among NUM_REQ requesters, e.g. L2 I-side, L2 D-side, a prefetcher and a debug port.
- Grants are round-robin, with one outstanding transaction at a time. The request fields are held stable toward the L3 until the cache signals completion, and the result is routed back to the owner.
- Also sequences cache flushes. A flush is serviced between transactions, never in the middle of one.
- Sits between the L2 level and the L3 data cache in the MEM-stage hierarchy.

---
 rtl/l3_arb_pkg.sv | 23 ++
 rtl/l3_rr_pick.sv | 34 +++
 rtl/l3_port_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_l3_port_arbiter.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l3_arb_pkg.sv
// Shared types and helpers for the L3 data-cache port arbiter.
package l3_arb_pkg;

  localparam int unsigned ADDR_W = 32;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp,
    StFlush
  } arb_state_e;

  // Width of an index into n items, never less than one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/l3_rr_pick.sv
// Combinational round-robin picker: first set request after last_i, wrapping.
module l3_rr_pick
  import l3_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  always_comb begin
    int unsigned k;
    logic [IDX_W-1:0] kk;
    k       = 0;
    kk      = '0;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k  = (32'(last_i) + 32'd1 + i) % NUM_REQ;
      kk = IDX_W'(k);
      if (!any_o && req_i[kk]) begin
        any_o       = 1'b1;
        idx_o       = kk;
        grant_o[kk] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l3_port_arbiter.sv
// Round-robin arbiter sharing the L3 data-cache port; one transaction in flight,
// flushes slotted between transactions. Define L3_ARB_TIMEOUT_EN for the BUSY watchdog.
module l3_port_arbiter
  import l3_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_LENGTH    = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]      req_addr,
  input  logic [NUM_REQ-1:0]             req_is_store,
  input  logic [NUM_REQ*DATA_LENGTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_LENGTH-1:0]         rsp_rdata,
  output logic                           rsp_err,
  input  logic                           flush_req,
  output logic                           flush_done,
  output logic                           l3_access_valid,
  output logic [ADDR_W-1:0]              l3_access_addr,
  output logic                           l3_access_is_store,
  output logic [DATA_LENGTH-1:0]         l3_store_data,
  input  logic [DATA_LENGTH-1:0]         l3_load_data,
  input  logic                           l3_done,
  output logic                           l3_flush
);

  localparam int unsigned IDX_W = clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_cfg_err
    $error("l3_port_arbiter: unsupported parameter set");
  end

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       last_grant_q;
  logic [IDX_W-1:0]       owner_q;
  logic [ADDR_W-1:0]      addr_q;
  logic                   is_store_q;
  logic [DATA_LENGTH-1:0] wdata_q;
  logic [DATA_LENGTH-1:0] rdata_q;
  logic                   flush_pending_q, flush_pending_d;

  logic [NUM_REQ-1:0]     pick_grant;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;
  logic                   flush_wanted;
  logic                   accept;
  logic                   timeout;

  logic [ADDR_W-1:0]      sel_addr;
  logic                   sel_store;
  logic [DATA_LENGTH-1:0] sel_wdata;

  l3_rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req_i  (req_valid),
    .last_i (last_grant_q),
    .grant_o(pick_grant),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // A flush always beats a new grant while idle.
  assign flush_wanted = flush_pending_q | flush_req;
  assign accept       = (state_q == StIdle) & ~flush_wanted & pick_any;

  always_comb begin
    sel_addr  = '0;
    sel_store = 1'b0;
    sel_wdata = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (pick_grant[k]) begin
        sel_addr  = req_addr[k*ADDR_W +: ADDR_W];
        sel_store = req_is_store[k];
        sel_wdata = req_wdata[k*DATA_LENGTH +: DATA_LENGTH];
      end
    end
  end

`ifdef L3_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             err_q, err_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    err_d     = err_q;
    if (accept) begin
      tmo_cnt_d = '0;
    end else if (state_q == StBusy) begin
      tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
    end
    // l3_done wins over a coinciding timeout.
    if (state_q == StBusy) begin
      if (l3_done) begin
        err_d = 1'b0;
      end else if (timeout) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign timeout = (state_q == StBusy) && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rsp_err = (state_q == StResp) && err_q;
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (flush_wanted) begin
          state_d = StFlush;
        end else if (pick_any) begin
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (l3_done || timeout) begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      StFlush: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready          = '0;
    rsp_valid          = '0;
    rsp_rdata          = '0;
    flush_done         = 1'b0;
    l3_flush           = 1'b0;
    l3_access_valid    = 1'b0;
    l3_access_addr     = '0;
    l3_access_is_store = 1'b0;
    l3_store_data      = '0;
    case (state_q)
      StIdle: begin
        // Gate on rst so nothing is accepted while reset is held.
        if (accept && !rst) begin
          req_ready = pick_grant;
        end
      end
      StBusy: begin
        l3_access_valid    = 1'b1;
        l3_access_addr     = addr_q;
        l3_access_is_store = is_store_q;
        l3_store_data      = wdata_q;
      end
      StResp: begin
        rsp_valid[owner_q] = 1'b1;
        rsp_rdata          = rdata_q;
      end
      StFlush: begin
        flush_done = 1'b1;
        l3_flush   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    flush_pending_d = flush_pending_q;
    if (state_q == StFlush) begin
      flush_pending_d = 1'b0;
    end
    // Requests seen while idle are serviced directly, so they never set the sticky bit.
    if (flush_req && state_q != StIdle) begin
      flush_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q    <= IDX_W'(NUM_REQ - 1);
      owner_q         <= '0;
      addr_q          <= '0;
      is_store_q      <= 1'b0;
      wdata_q         <= '0;
      rdata_q         <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      flush_pending_q <= flush_pending_d;
      if (accept) begin
        owner_q    <= pick_idx;
        addr_q     <= sel_addr;
        is_store_q <= sel_store;
        wdata_q    <= sel_wdata;
      end
      if (state_q == StBusy) begin
        if (l3_done) begin
          rdata_q <= is_store_q ? '0 : l3_load_data;
        end else if (timeout) begin
          rdata_q <= '0;
        end
      end
      if (state_q == StResp) begin
        last_grant_q <= owner_q;
      end
    end
  end

endmodule

// File: tb/tb_l3_port_arbiter.sv
// Scoreboard bench for l3_port_arbiter: expected grants/flushes queued with stimulus,
// checked as the arbiter accepts, drives L3 and responds.
`timescale 1ns/1ps
module tb_l3_port_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DW      = 32;
  localparam int unsigned TMO     = 16;

  logic                    clk;
  logic                    rst;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*32-1:0]   req_addr;
  logic [NUM_REQ-1:0]      req_is_store;
  logic [NUM_REQ*DW-1:0]   req_wdata;
  logic [NUM_REQ-1:0]      rsp_valid;
  logic [DW-1:0]           rsp_rdata;
  logic                    rsp_err;
  logic                    flush_req;
  logic                    flush_done;
  logic                    l3_access_valid;
  logic [31:0]             l3_access_addr;
  logic                    l3_access_is_store;
  logic [DW-1:0]           l3_store_data;
  logic [DW-1:0]           l3_load_data;
  logic                    l3_done;
  logic                    l3_flush;

  l3_port_arbiter #(
    .NUM_REQ       (NUM_REQ),
    .DATA_LENGTH   (DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_addr          (req_addr),
    .req_is_store      (req_is_store),
    .req_wdata         (req_wdata),
    .rsp_valid         (rsp_valid),
    .rsp_rdata         (rsp_rdata),
    .rsp_err           (rsp_err),
    .flush_req         (flush_req),
    .flush_done        (flush_done),
    .l3_access_valid   (l3_access_valid),
    .l3_access_addr    (l3_access_addr),
    .l3_access_is_store(l3_access_is_store),
    .l3_store_data     (l3_store_data),
    .l3_load_data      (l3_load_data),
    .l3_done           (l3_done),
    .l3_flush          (l3_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          owner;
    logic [31:0] addr;
    bit          st;
    logic [31:0] wdata;
  } req_t;

  // lat: access cycle carrying l3_done (0 = never); acc: expected access cycles.
  typedef struct {
    bit          flush;
    int          owner;
    logic [31:0] addr;
    bit          st;
    logic [31:0] wdata;
    int          lat;
    int          acc;
    logic [31:0] rdata;
    bit          err;
  } ev_t;

  int                 checks;
  int                 errors;
  req_t               pend_q[$];
  ev_t                ev_q[$];
  ev_t                cur;
  bit                 inflight;
  int                 acc_cnt;
  int                 cyc;
  int                 accept_cyc;
  int                 busy_cnt;
  int                 rsp_cnt;
  int                 flush_cnt;
  int                 flush_pulses;
  bit                 stray_done;
  logic [NUM_REQ-1:0] ready_seen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] l3_mem(input logic [31:0] a);
    return (a == 32'h0000_1040) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_C3C3);
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input int k);
    logic [NUM_REQ-1:0] v;
    v = NUM_REQ'(1) << k;
    return v;
  endfunction

  task automatic add_req(input int k, input logic [31:0] addr, input bit st,
                         input logic [31:0] wdata, input int lat, input int acc, input bit err);
    req_t r;
    ev_t  e;
    r.owner = k;
    r.addr  = addr;
    r.st    = st;
    r.wdata = wdata;
    pend_q.push_back(r);
    e.flush = 1'b0;
    e.owner = k;
    e.addr  = addr;
    e.st    = st;
    e.wdata = wdata;
    e.lat   = lat;
    e.acc   = acc;
    e.err   = err;
    e.rdata = (st || err) ? 32'h0 : l3_mem(addr);
    ev_q.push_back(e);
  endtask

  task automatic add_txn(input int k, input logic [31:0] addr, input bit st,
                         input logic [31:0] wdata, input int lat);
    add_req(k, addr, st, wdata, lat, lat, 1'b0);
  endtask

  task automatic add_flush();
    ev_t e;
    e       = '{default: 0};
    e.flush = 1'b1;
    ev_q.push_back(e);
  endtask

  task automatic sample();
    bit ok;
    if (flush_done || l3_flush) check("flush_strobe_pair", l3_flush, flush_done);
    if (req_ready != '0) begin
      ready_seen = req_ready;
      check("grant_while_inflight", inflight, 0);
      ok = (ev_q.size() != 0) && !ev_q[0].flush;
      check("grant_expected", ok, 1);
      if (ok) begin
        check("grant_owner", req_ready, onehot(ev_q[0].owner));
        cur        = ev_q.pop_front();
        inflight   = 1'b1;
        acc_cnt    = 0;
        accept_cyc = cyc;
      end
    end
    if (flush_done) begin
      flush_cnt++;
      check("flush_mid_txn", inflight, 0);
      ok = (ev_q.size() != 0) && ev_q[0].flush;
      check("flush_expected", ok, 1);
      if (ok) void'(ev_q.pop_front());
    end
    if (l3_access_valid) begin
      check("access_owned", inflight, 1);
      if (inflight) begin
        check("acc_addr", l3_access_addr, cur.addr);
        check("acc_store", l3_access_is_store, cur.st);
        check("acc_wdata", l3_store_data, cur.wdata);
        acc_cnt++;
      end
    end
    if (rsp_valid != '0) begin
      rsp_cnt++;
      check("rsp_owned", inflight, 1);
      if (inflight) begin
        check("rsp_onehot", rsp_valid, onehot(cur.owner));
        check("rsp_rdata", rsp_rdata, cur.rdata);
        check("rsp_err", rsp_err, cur.err);
        check("acc_cycles", acc_cnt, cur.acc);
        check("rsp_latency", cyc - accept_cyc, cur.acc + 1);
        inflight = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic drive();
    logic [NUM_REQ-1:0]    v;
    logic [NUM_REQ-1:0]    s;
    logic [NUM_REQ*32-1:0] a;
    logic [NUM_REQ*DW-1:0] w;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (ready_seen[k]) begin
        for (int i = 0; i < pend_q.size(); i++) begin
          if (pend_q[i].owner == k) begin
            pend_q.delete(i);
            break;
          end
        end
      end
    end
    ready_seen = '0;
    v = '0;
    s = '0;
    a = '0;
    w = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < pend_q.size(); i++) begin
        if (pend_q[i].owner == k) begin
          v[k]          = 1'b1;
          s[k]          = pend_q[i].st;
          a[k*32 +: 32] = pend_q[i].addr;
          w[k*DW +: DW] = pend_q[i].wdata;
          break;
        end
      end
    end
    req_valid    = v;
    req_is_store = s;
    req_addr     = a;
    req_wdata    = w;
    flush_req    = (flush_pulses > 0);
    if (flush_pulses > 0) flush_pulses--;
    if (l3_access_valid) begin
      busy_cnt++;
      l3_done      = inflight && (cur.lat != 0) && (busy_cnt == cur.lat);
      l3_load_data = l3_mem(cur.addr);
    end else begin
      busy_cnt     = 0;
      l3_done      = stray_done;
      l3_load_data = 32'hBAD0_0BAD;
      stray_done   = 1'b0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((ev_q.size() != 0 || inflight || pend_q.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    check(tag, ev_q.size() + pend_q.size() + int'(inflight), 0);
    repeat (2) cycle();
  endtask

  task automatic wait_accept(input string tag, input int min_acc, input int budget);
    int n;
    n = 0;
    while (!(inflight && acc_cnt >= min_acc) && n < budget) begin
      cycle();
      n++;
    end
    check(tag, inflight && acc_cnt >= min_acc, 1);
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_req_ready"}, req_ready, 0);
    check({pfx, "_rsp_valid"}, rsp_valid, 0);
    check({pfx, "_rsp_rdata"}, rsp_rdata, 0);
    check({pfx, "_rsp_err"}, rsp_err, 0);
    check({pfx, "_flush_done"}, flush_done, 0);
    check({pfx, "_l3_flush"}, l3_flush, 0);
    check({pfx, "_acc_valid"}, l3_access_valid, 0);
    check({pfx, "_acc_addr"}, l3_access_addr, 0);
    check({pfx, "_acc_store"}, l3_access_is_store, 0);
    check({pfx, "_store_data"}, l3_store_data, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached got 1 expected 0");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int f0;
    checks       = 0;
    errors       = 0;
    inflight     = 1'b0;
    acc_cnt      = 0;
    cyc          = 0;
    accept_cyc   = 0;
    busy_cnt     = 0;
    rsp_cnt      = 0;
    flush_cnt    = 0;
    flush_pulses = 0;
    stray_done   = 1'b0;
    ready_seen   = '0;
    cur          = '{default: 0};

    // Reset with every input active: outputs must still be quiet.
    rst          = 1'b1;
    req_valid    = '1;
    req_is_store = '1;
    req_addr     = {NUM_REQ{32'hFFFF_0000}};
    req_wdata    = {NUM_REQ{32'h1111_2222}};
    flush_req    = 1'b1;
    l3_done      = 1'b1;
    l3_load_data = '1;
    #12;
    check_outputs_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive();
    repeat (2) cycle();

    // Fairness: everyone valid, requester 0 first after reset.
    r0 = rsp_cnt;
    add_txn(0, 32'h0000_0100, 1'b0, 32'h0, 1);
    add_txn(1, 32'h0000_0204, 1'b0, 32'h0, 1);
    add_txn(2, 32'h0000_0308, 1'b1, 32'hA1A2_A3A4, 1);
    add_txn(3, 32'h0000_040C, 1'b0, 32'h0, 1);
    add_txn(0, 32'h0000_0110, 1'b0, 32'h0, 1);
    drain("fair_drain", 200);
    check("fair_rsp_count", rsp_cnt - r0, 5);

    // Single load, L3 answers on the fifth access cycle.
    add_txn(1, 32'h0000_1040, 1'b0, 32'h0, 5);
    drain("load_drain", 100);

    // Store returns zero data even though L3 drives load data.
    add_txn(2, 32'h0000_0080, 1'b1, 32'h1234_5678, 2);
    drain("store_drain", 100);

    // Stray l3_done while idle must not produce a response.
    r0 = rsp_cnt;
    stray_done = 1'b1;
    repeat (4) cycle();
    check("stray_done_ignored", rsp_cnt, r0);

    // Flush and request together while idle: flush goes first.
    f0 = flush_cnt;
    add_flush();
    add_txn(0, 32'h0000_0400, 1'b0, 32'h0, 3);
    flush_pulses = 1;
    drain("idle_flush_drain", 100);
    check("idle_flush_count", flush_cnt - f0, 1);

    // Two flush pulses mid-transaction with requester 3 waiting: one flush after RESP.
    f0 = flush_cnt;
    add_txn(1, 32'h0000_0500, 1'b0, 32'h0, 4);
    wait_accept("busy_flush_accept", 0, 20);
    add_flush();
    add_txn(3, 32'h0000_0600, 1'b1, 32'hCAFE_F00D, 1);
    flush_pulses = 2;
    drain("busy_flush_drain", 100);
    check("busy_flush_count", flush_cnt - f0, 1);

    // Move last_grant to 1 so a lost reset of it would favour requester 2.
    add_txn(1, 32'h0000_0700, 1'b0, 32'h0, 1);
    drain("pre_reset_drain", 100);

    // Reset in the middle of a long transaction.
    r0 = rsp_cnt;
    add_txn(2, 32'h0000_0800, 1'b0, 32'h0, 30);
    wait_accept("rst_busy_accept", 3, 40);
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("mid_reset");
    ev_q.delete();
    pend_q.delete();
    inflight   = 1'b0;
    ready_seen = '0;
    busy_cnt   = 0;
    req_valid  = '1;
    repeat (3) begin
      @(negedge clk);
      check("rst_hold_rsp", rsp_valid, 0);
      check("rst_hold_ready", req_ready, 0);
    end
    check("rst_no_rsp", rsp_cnt, r0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    add_txn(0, 32'h0000_0A00, 1'b0, 32'h0, 2);
    add_txn(2, 32'h0000_0900, 1'b0, 32'h0, 2);
    drive();
    drain("post_reset_drain", 100);

`ifdef L3_ARB_TIMEOUT_EN
    // L3 never answers: error response 17 cycles after accept.
    add_req(1, 32'h0000_0B00, 1'b0, 32'h0, 0, TMO, 1'b1);
    drain("timeout_drain", 100);
    // l3_done on the last counted cycle beats the timeout.
    add_req(3, 32'h0000_0C00, 1'b0, 32'h0, TMO, TMO, 1'b0);
    drain("timeout_tie_drain", 100);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
